// File: rtl/uart_tx_arbiter_if.sv
// rtl/uart_tx_arbiter_if.sv - requester byte streams and TX-engine handshake of uart_tx_arbiter
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_last;
  logic [NUM_REQ-1:0]   req_ready;
  logic [NUM_REQ-1:0]   grant;
  logic                 tx_start;
  logic [7:0]           tx_data;
  logic                 tx_busy;
  logic                 timeout_pulse;

  modport slave (
    input  req_valid, req_data, req_last, tx_busy,
    output req_ready, grant, tx_start, tx_data, timeout_pulse
  );

  modport master (
    output req_valid, req_data, req_last, tx_busy,
    input  req_ready, grant, tx_start, tx_data, timeout_pulse
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - packet-locked round-robin arbiter feeding one UART TX engine
// Optional ARB_TIMEOUT_EN: forced release of a grant whose owner stalls mid-packet.
module uart_tx_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 23400
) (
  input  logic             clk,
  input  logic             rst_n,
  uart_tx_arbiter_if.slave bus
);
  localparam int IW = $clog2(NUM_REQ);

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_LOAD      = 2'd1;
  localparam logic [1:0] ST_WAIT_ACK  = 2'd2;
  localparam logic [1:0] ST_WAIT_DONE = 2'd3;

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("uart_tx_arbiter: parameter out of range");
  end

  logic [1:0]         state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [IW-1:0]      gidx_q, gidx_d;
  logic [IW-1:0]      ptr_q, ptr_d;
  logic               tx_start_q, tx_start_d;
  logic [7:0]         tx_data_q, tx_data_d;
  logic               last_q, last_d;

  logic               pick_found;
  logic [IW-1:0]      pick_idx;
  logic [IW-1:0]      cand;
  logic [IW-1:0]      gidx_next;
  logic               sel_valid;
  logic               sel_last;
  logic [7:0]         sel_data;

  // First valid requester at or after the pointer, wrapping.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = IW'((int'(ptr_q) + k) % NUM_REQ);
      if (!pick_found && bus.req_valid[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (grant_q[k]) begin
        sel_valid = bus.req_valid[k];
        sel_last  = bus.req_last[k];
        sel_data  = bus.req_data[8*k +: 8];
      end
    end
  end

  assign gidx_next = (gidx_q == IW'(NUM_REQ - 1)) ? '0 : gidx_q + IW'(1);

`ifdef ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          sent_q, sent_d;
  logic          timeout_pulse_q, timeout_pulse_d;
`endif

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    gidx_d     = gidx_q;
    ptr_d      = ptr_q;
    tx_start_d = 1'b0;
    tx_data_d  = tx_data_q;
    last_d     = last_q;
`ifdef ARB_TIMEOUT_EN
    cnt_d           = '0;
    sent_d          = sent_q;
    timeout_pulse_d = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          grant_d           = '0;
          grant_d[pick_idx] = 1'b1;
          gidx_d            = pick_idx;
          state_d           = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (sel_valid) begin
          tx_data_d  = sel_data;
          tx_start_d = 1'b1;
          last_d     = sel_last;
          state_d    = ST_WAIT_ACK;
`ifdef ARB_TIMEOUT_EN
          sent_d     = 1'b1;
`endif
        end
`ifdef ARB_TIMEOUT_EN
        else if (sent_q) begin
          if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
            grant_d         = '0;
            ptr_d           = gidx_next;
            state_d         = ST_IDLE;
            sent_d          = 1'b0;
            timeout_pulse_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
`endif
      end
      ST_WAIT_ACK: begin
        if (bus.tx_busy) begin
          state_d = ST_WAIT_DONE;
        end
      end
      ST_WAIT_DONE: begin
        if (!bus.tx_busy) begin
          if (last_q) begin
            grant_d = '0;
            ptr_d   = gidx_next;
            state_d = ST_IDLE;
`ifdef ARB_TIMEOUT_EN
            sent_d  = 1'b0;
`endif
          end else begin
            state_d = ST_LOAD;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      grant_q    <= '0;
      gidx_q     <= '0;
      ptr_q      <= '0;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
      last_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      gidx_q     <= gidx_d;
      ptr_q      <= ptr_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
      last_q     <= last_d;
    end
  end

`ifdef ARB_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q           <= '0;
      sent_q          <= 1'b0;
      timeout_pulse_q <= 1'b0;
    end else begin
      cnt_q           <= cnt_d;
      sent_q          <= sent_d;
      timeout_pulse_q <= timeout_pulse_d;
    end
  end

  assign bus.timeout_pulse = timeout_pulse_q;
`else
  assign bus.timeout_pulse = 1'b0;
`endif

  assign bus.req_ready = (state_q == ST_LOAD) ? grant_q : '0;
  assign bus.grant     = grant_q;
  assign bus.tx_start  = tx_start_q;
  assign bus.tx_data   = tx_data_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - directed vectors for uart_tx_arbiter with a 10-cycle TX engine model
module tb_uart_tx_arbiter;
  localparam int NR = 4;
`ifdef ARB_TIMEOUT_EN
  localparam int TO = 50;
`else
  localparam int TO = 23400;
`endif
  localparam int BUSY_LEN = 10;
  localparam int LOGN     = 64;

  localparam logic [31:0] EXP_CONT [6] = '{32'h0A0, 32'h0A1, 32'h2C0, 32'h2C1, 32'h3D0, 32'h3D1};
  localparam logic [31:0] EXP_FAIR [8] = '{32'h060, 32'h170, 32'h061, 32'h171,
                                           32'h062, 32'h172, 32'h063, 32'h173};

  logic clk = 1'b0;
  logic rst_n;

  uart_tx_arbiter_if #(.NUM_REQ(NR)) bus ();

  uart_tx_arbiter #(.NUM_REQ(NR), .TIMEOUT_CYCLES(TO)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int          n_vec  = 0;
  int          n_miss = 0;
  logic [8:0]  rq_mem  [NR][16];
  int          rq_len  [NR];
  int          rq_hd   [NR];
  bit          rq_hold [NR];
  logic [NR-1:0] xfer;
  int          n_xfer = 0;
  logic [7:0]  sent_data [LOGN];
  int          sent_req  [LOGN];
  int          n_sent    = 0;
  int          busy_cnt  = 0;
  int          viol      = 0;
  int          pulse_cnt = 0;
  logic        prev_start = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int onehot_idx(input logic [NR-1:0] g);
    int r = -1;
    for (int i = 0; i < NR; i++) if (g[i]) r = i;
    return r;
  endfunction

  function automatic logic [31:0] logent(input int k);
    if (k >= LOGN) return 32'hdeadbeef;
    return 32'(sent_req[k] * 256) + 32'(sent_data[k]);
  endfunction

  function automatic bit drained();
    bit d = 1'b1;
    for (int i = 0; i < NR; i++) if (rq_hd[i] < rq_len[i] && !rq_hold[i]) d = 1'b0;
    return d;
  endfunction

  task automatic push(input int r, input logic [7:0] d, input logic l);
    rq_mem[r][rq_len[r]] = {l, d};
    rq_len[r]++;
  endtask

  task automatic clr_q();
    for (int i = 0; i < NR; i++) begin
      rq_len[i] = 0; rq_hd[i] = 0; rq_hold[i] = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    clr_q();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    bit done = 1'b0;
    for (int c = 0; c < budget && !done; c++) begin
      @(negedge clk);
      done = (bus.grant == '0) && !bus.tx_busy && drained();
    end
    check(tag, 32'(done), 32'd1);
  endtask

  task automatic wait_sent(input string tag, input int target, input int budget);
    bit ok = 1'b0;
    for (int c = 0; c < budget && !ok; c++) begin
      @(negedge clk);
      ok = (n_sent >= target);
    end
    check(tag, 32'(ok), 32'd1);
  endtask

  // Requesters: present queue head, pop after an accepted transfer.
  initial begin
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.req_last  = '0;
    forever begin
      @(negedge clk);
      xfer = bus.req_valid & bus.req_ready & {NR{rst_n}};
      @(posedge clk);
      #2;
      for (int i = 0; i < NR; i++) begin
        if (xfer[i]) begin
          rq_hd[i]++;
          n_xfer++;
        end
        if (rq_hd[i] < rq_len[i] && !rq_hold[i]) begin
          bus.req_valid[i]        = 1'b1;
          bus.req_data[8*i +: 8]  = rq_mem[i][rq_hd[i]][7:0];
          bus.req_last[i]         = rq_mem[i][rq_hd[i]][8];
        end else begin
          bus.req_valid[i] = 1'b0;
        end
      end
    end
  end

  // TX engine model and protocol monitor.
  initial begin
    bus.tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.tx_start) begin
        if (n_sent < LOGN) begin
          sent_data[n_sent] = bus.tx_data;
          sent_req[n_sent]  = onehot_idx(bus.grant);
        end
        n_sent++;
        busy_cnt = BUSY_LEN;
      end else if (busy_cnt > 0) begin
        busy_cnt--;
      end
      bus.tx_busy = (busy_cnt > 0);
      if ((bus.req_ready & ~bus.grant) != '0) viol++;
      if ($countones(bus.grant) > 1) viol++;
      if (bus.tx_start && prev_start) viol++;
      prev_start = bus.tx_start;
      if (bus.timeout_pulse) pulse_cnt++;
    end
  end

  initial begin
    int base;
    int lockv;
    rst_n = 1'b0;
    clr_q();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_grant", 32'(bus.grant), 32'h0);
    check("rst_ready", 32'(bus.req_ready), 32'h0);
    check("rst_start", 32'(bus.tx_start), 32'h0);
    check("rst_data", 32'(bus.tx_data), 32'h0);
    check("rst_tmo", 32'(bus.timeout_pulse), 32'h0);

    // Single requester, exact latency.
    @(posedge clk); #1;
    rst_n = 1'b1;
    push(0, 8'h41, 1'b0);
    push(0, 8'h42, 1'b1);
    @(negedge clk);
    check("t1_c0_grant", 32'(bus.grant), 32'h0);
    @(negedge clk);
    check("t1_c1_grant", 32'(bus.grant), 32'h1);
    check("t1_c1_ready", 32'(bus.req_ready), 32'h1);
    @(negedge clk);
    check("t1_c2_start", 32'(bus.tx_start), 32'h1);
    check("t1_c2_data", 32'(bus.tx_data), 32'h41);
    @(negedge clk);
    check("t1_c3_start", 32'(bus.tx_start), 32'h0);
    repeat (9) @(negedge clk);
    check("t1_ready_busy", 32'(bus.req_ready), 32'h0);
    @(negedge clk);
    check("t1_ready_after", 32'(bus.req_ready), 32'h1);
    @(negedge clk);
    check("t1_b2_start", 32'(bus.tx_start), 32'h1);
    check("t1_b2_data", 32'(bus.tx_data), 32'h42);
    wait_idle("t1_idle", 200);
    check("t1_count", 32'(n_sent), 32'd2);
    check("t1_hold_data", 32'(bus.tx_data), 32'h42);

    // Pointer moved to 1: req1 beats req0.
    @(posedge clk); #1;
    base = n_sent;
    push(0, 8'h50, 1'b1);
    push(1, 8'h51, 1'b1);
    wait_idle("t1p_idle", 200);
    check("t1p_first", logent(base), 32'h151);
    check("t1p_second", logent(base + 1), 32'h050);

    // Contention from reset.
    do_reset();
    base = n_sent;
    push(0, 8'hA0, 1'b0); push(0, 8'hA1, 1'b1);
    push(2, 8'hC0, 1'b0); push(2, 8'hC1, 1'b1);
    push(3, 8'hD0, 1'b0); push(3, 8'hD1, 1'b1);
    wait_idle("t2_idle", 400);
    for (int k = 0; k < 6; k++) check("t2_order", logent(base + k), EXP_CONT[k]);

    // Fairness between two streaming requesters.
    do_reset();
    base = n_sent;
    for (int k = 0; k < 4; k++) begin
      push(0, 8'(8'h60 + k), 1'b1);
      push(1, 8'(8'h70 + k), 1'b1);
    end
    wait_idle("t3_idle", 500);
    for (int k = 0; k < 8; k++) check("t3_order", logent(base + k), EXP_FAIR[k]);

`ifdef ARB_TIMEOUT_EN
    // Stalled owner is released after the timeout.
    do_reset();
    base = n_sent;
    lockv = pulse_cnt;
    push(2, 8'hC5, 1'b0);
    push(2, 8'hC6, 1'b1);
    wait_sent("t6_first", base + 1, 50);
    @(posedge clk); #1;
    rq_hold[2] = 1'b1;
    push(3, 8'hD5, 1'b1);
    begin
      bit seen = 1'b0;
      int delta = 0;
      for (int c = 0; c < 50 && !seen; c++) begin
        @(negedge clk);
        seen = bus.req_ready[2];
      end
      check("t6_load", 32'(seen), 32'd1);
      seen = 1'b0;
      for (int c = 0; c < 200 && !seen; c++) begin
        @(negedge clk);
        delta++;
        seen = bus.timeout_pulse;
      end
      check("t6_delta", 32'(delta), 32'd50);
      check("t6_grant_rel", 32'(bus.grant), 32'h0);
      @(negedge clk);
      check("t6_pulse_len", 32'(bus.timeout_pulse), 32'h0);
      check("t6_next_grant", 32'(bus.grant), 32'h8);
    end
    @(posedge clk); #1;
    rq_hold[2] = 1'b0;
    wait_idle("t6_idle", 400);
    check("t6_pulses", 32'(pulse_cnt - lockv), 32'd1);
    check("t6_o0", logent(base), 32'h2C5);
    check("t6_o1", logent(base + 1), 32'h3D5);
    check("t6_o2", logent(base + 2), 32'h2C6);
`else
    // Packet lock while the owner stalls.
    do_reset();
    base = n_sent;
    push(1, 8'h81, 1'b0);
    push(1, 8'h82, 1'b1);
    wait_sent("t4_first", base + 1, 50);
    @(posedge clk); #1;
    rq_hold[1] = 1'b1;
    push(0, 8'h90, 1'b1);
    lockv = 0;
    repeat (500) begin
      @(negedge clk);
      if (bus.grant != 4'b0010) lockv++;
      if (bus.req_ready[0]) lockv++;
    end
    check("t4_lock", 32'(lockv), 32'd0);
    @(posedge clk); #1;
    rq_hold[1] = 1'b0;
    wait_idle("t4_idle", 400);
    check("t4_o0", logent(base), 32'h181);
    check("t4_o1", logent(base + 1), 32'h182);
    check("t4_o2", logent(base + 2), 32'h090);
    check("t4_no_pulse", 32'(pulse_cnt), 32'd0);
`endif

    // Reset during WAIT_DONE.
    do_reset();
    base = n_sent;
    push(1, 8'hB1, 1'b0);
    push(1, 8'hB2, 1'b1);
    wait_sent("t5_first", base + 1, 50);
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    rq_hd[1] = rq_len[1];
    push(3, 8'hD9, 1'b1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("t5_rst_grant", 32'(bus.grant), 32'h0);
    check("t5_rst_start", 32'(bus.tx_start), 32'h0);
    check("t5_rst_ready", 32'(bus.req_ready), 32'h0);
    @(negedge clk);
    check("t5_req3_grant", 32'(bus.grant), 32'h8);
    wait_idle("t5_idle", 300);
    check("t5_o1", logent(base + 1), 32'h3D9);
    check("t5_count", 32'(n_sent - base), 32'd2);

    check("protocol_viol", 32'(viol), 32'd0);
    check("xfer_vs_start", 32'(n_xfer), 32'(n_sent));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
